// File: rtl/handshake_rr_arbiter_pkg.sv
// Shared types and width helpers for the round-robin handshake arbiters.
package handshake_arb_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Counter holds 0..GRANT_HOLD-1; the grant ends on the beat taken at GRANT_HOLD-1.
    function automatic int beat_cnt_width(input int hold);
        return (hold > 1) ? $clog2(hold) : 1;
    endfunction

endpackage

// File: rtl/handshake_rr_arbiter_pick.sv
// Combinational round-robin pick: first requester after last_ptr, wrapping at NUM_MASTERS.
module rr_priority_pick
    import handshake_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int IDX_W       = idx_width(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]       last_ptr,
    output logic [IDX_W-1:0]       pick,
    output logic                   any_req
);

    logic [2*NUM_MASTERS-1:0] w_req_dbl;
    logic [NUM_MASTERS-1:0]   w_rot;
    logic [IDX_W-1:0]         w_cand;
    logic                     w_found;

    // Rotate so bit 0 is the candidate after last_ptr; the candidate index wraps
    // explicitly so a non-power-of-two count never yields an out-of-range pick.
    always_comb begin
        pick      = '0;
        w_found   = 1'b0;
        w_cand    = (last_ptr >= IDX_W'(NUM_MASTERS - 1)) ? '0 : last_ptr + 1'b1;
        w_req_dbl = {req, req} >> w_cand;
        w_rot     = w_req_dbl[NUM_MASTERS-1:0];
        for (int j = 0; j < NUM_MASTERS; j++) begin
            if (!w_found && w_rot[0]) begin
                pick    = w_cand;
                w_found = 1'b1;
            end
            w_rot  = w_rot >> 1;
            w_cand = (w_cand == IDX_W'(NUM_MASTERS - 1)) ? '0 : w_cand + 1'b1;
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/handshake_rr_arbiter.sv
// Round-robin arbiter: NUM_MASTERS valid/ready sources share one registered sink.
// A grant ends after GRANT_HOLD beats or when the granted source goes idle.
module handshake_rr_arbiter
    import handshake_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int DATA_WIDTH  = 32,
    parameter int GRANT_HOLD  = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] s_data,
    input  logic [NUM_MASTERS-1:0]            s_valid,
    output logic [NUM_MASTERS-1:0]            s_ready,
    output logic [DATA_WIDTH-1:0]             m_data,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [$clog2(NUM_MASTERS)-1:0]    grant_id,
    output logic                              grant_active
);

    localparam int IDX_W = idx_width(NUM_MASTERS);
    localparam int CNT_W = beat_cnt_width(GRANT_HOLD);

    state_t                 r_state;
    logic [IDX_W-1:0]       r_grant_id;
    logic [IDX_W-1:0]       r_last_ptr;
    logic [CNT_W-1:0]       r_beat_cnt;
    logic [DATA_WIDTH-1:0]  r_m_data;
    logic                   r_m_valid;

    logic [IDX_W-1:0]       w_pick;
    logic                   w_any_req;
    logic                   w_can_load;
    logic                   w_active;
    logic [NUM_MASTERS-1:0] w_grant_mask;
    logic [NUM_MASTERS-1:0] w_s_ready;
    logic                   w_src_valid;
    logic                   w_src_beat;
    logic                   w_last_beat;
    logic [DATA_WIDTH-1:0]  w_sel_data;

    rr_priority_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (IDX_W)
    ) u_pick (
        .req      (s_valid),
        .last_ptr (r_last_ptr),
        .pick     (w_pick),
        .any_req  (w_any_req)
    );

    assign w_can_load   = !r_m_valid || m_ready;
    assign w_active     = (r_state == ST_GRANT);
    assign w_grant_mask = NUM_MASTERS'(1) << r_grant_id;
    assign w_s_ready    = (w_active && w_can_load) ? w_grant_mask : '0;
    assign w_src_valid  = |(s_valid & w_grant_mask);
    assign w_src_beat   = |(s_valid & w_s_ready);
    assign w_last_beat  = (r_beat_cnt == CNT_W'(GRANT_HOLD - 1));
    assign w_sel_data   = s_data[int'(r_grant_id) * DATA_WIDTH +: DATA_WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_grant_id <= '0;
            r_last_ptr <= IDX_W'(NUM_MASTERS - 1);
            r_beat_cnt <= '0;
            r_m_data   <= '0;
            r_m_valid  <= 1'b0;
        end else begin
            // A new source beat wins over a sink beat, keeping m_valid high back-to-back.
            if (w_src_beat) begin
                r_m_data  <= w_sel_data;
                r_m_valid <= 1'b1;
            end else if (r_m_valid && m_ready) begin
                r_m_valid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_grant_id <= w_pick;
                        r_last_ptr <= w_pick;
                        r_beat_cnt <= '0;
                        r_state    <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (w_src_beat) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end
                    // Idle detection only counts while we could have taken a beat.
                    if ((w_src_beat && w_last_beat) || (!w_src_valid && w_can_load)) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign s_ready      = w_s_ready;
    assign m_data       = r_m_data;
    assign m_valid      = r_m_valid;
    assign grant_id     = r_grant_id;
    assign grant_active = w_active;

endmodule
